// File: rtl/b_resolve_queue_pkg.sv
// Shared constants and types for the branch resolve queue.
//   ENTRY_W / PUSH_W  : entry width and maximum pushes per cycle
//   DIR_BIT, TAG_*    : entry field layout (predicted direction, PC tag)
//   PASS_CORRECTION   : command code telling the GHR unit to roll back
//   GHR_CAP           : capacity of the speculative GHR (upper bound on DEPTH)
package b_resolve_queue_pkg;

  localparam int unsigned ENTRY_W = 9;
  localparam int unsigned PUSH_W  = 4;
  localparam int unsigned GHR_CAP = 20;

  localparam int unsigned DIR_BIT = 0;
  localparam int unsigned TAG_LSB = 1;
  localparam int unsigned TAG_MSB = 8;

  localparam logic [2:0] PASS_CORRECTION = 3'b111;

  typedef enum logic {
    ST_RUN,
    ST_RECOVER
  } state_t;

endpackage

// File: rtl/b_entry_ring.sv
// Circular entry storage for the resolve queue.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_num    : number of entries to write at the tail (already qualified)
//   push_data   : entries, entry k at [9k+8:9k], k=0 oldest
//   pop         : retire the head entry
//   flush       : drop every entry (tail snaps back to head)
//   head_entry  : oldest stored entry
//   count       : current occupancy
module b_entry_ring
  import b_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2:0]                push_num,
  input  logic [PUSH_W*ENTRY_W-1:0] push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [ENTRY_W-1:0]        head_entry,
  output logic [7:0]                count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;

  // Modulo-DEPTH pointer advance; inc never exceeds PUSH_W < DEPTH.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] ptr,
                                                input int unsigned inc);
    int unsigned s;
    s = int'(ptr) + inc;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  assign head_entry = mem[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      tail  <= head;
      count <= '0;
    end else begin
      for (int unsigned k = 0; k < PUSH_W; k++) begin
        if (k < 32'(push_num))
          mem[wrap_add(tail, k)] <= push_data[k*ENTRY_W +: ENTRY_W];
      end
      if (pop) head <= wrap_add(head, 1);
      tail  <= wrap_add(tail, 32'(push_num));
      count <= count - 8'(pop) + 8'(push_num);
    end
  end

endmodule

// File: rtl/b_resolve_queue.sv
// In-order tracker for predicted conditional branches between fetch and execute.
//   fire, rst          : clock, asynchronous active-low reset
//   i_pushNum_3/36     : up to 4 predicted branches pushed per cycle
//   i_resolve*         : execute resolves the oldest pending branch
//   o_ready            : room for a full push and not recovering
//   o_passBNum_3, o_newPendingB_8, o_newGHREntry_36 : GHR unit update command
//   o_pendingB_8       : current occupancy
//   o_redirect*        : one-cycle fetch redirect on mispredict
//   o_err              : sticky overflow / resolve-on-empty / resolve-in-recovery
module b_resolve_queue
  import b_resolve_queue_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic                      fire,
  input  logic                      rst,
  input  logic [2:0]                i_pushNum_3,
  input  logic [PUSH_W*ENTRY_W-1:0] i_pushEntry_36,
  input  logic                      i_resolveValid,
  input  logic                      i_resolveTaken,
  output logic                      o_ready,
  output logic [2:0]                o_passBNum_3,
  output logic [7:0]                o_newPendingB_8,
  output logic [PUSH_W*ENTRY_W-1:0] o_newGHREntry_36,
  output logic [7:0]                o_pendingB_8,
  output logic                      o_redirect,
  output logic                      o_redirectTaken,
  output logic [7:0]                o_redirectTag_8,
  output logic                      o_err
);

  state_t                    state;
  logic [3:0]                rec_cnt;
  logic [7:0]                count;
  logic [7:0]                count_next;
  logic [7:0]                avail;
  logic [ENTRY_W-1:0]        head_entry;
  logic                      mispred;
  logic                      match_pop;
  logic                      push_ok;
  logic                      err_set;
  logic                      ready_next;
  logic [2:0]                ring_push_num;
  logic [PUSH_W*ENTRY_W-1:0] ghr_next;

  b_entry_ring #(
    .DEPTH(DEPTH)
  ) u_ring (
    .clk       (fire),
    .rst_n     (rst),
    .push_num  (ring_push_num),
    .push_data (i_pushEntry_36),
    .pop       (match_pop),
    .flush     (mispred),
    .head_entry(head_entry),
    .count     (count)
  );

  assign o_pendingB_8 = count;

  always_comb begin
    mispred   = 1'b0;
    match_pop = 1'b0;
    push_ok   = 1'b0;
    err_set   = 1'b0;
    ghr_next  = '0;
    avail     = 8'(DEPTH) - count;

    if (state == ST_RUN) begin
      if (i_resolveValid) begin
        if (count == '0)                                  err_set   = 1'b1;
        else if (i_resolveTaken == head_entry[DIR_BIT])   match_pop = 1'b1;
        else                                              mispred   = 1'b1;
      end
      // A same-cycle matched pop frees a slot for the push.
      if (match_pop) avail = avail + 8'd1;
      // On mispredict the push is wrong-path: silently discarded.
      if (!mispred && i_pushNum_3 != '0) begin
        if (32'(i_pushNum_3) <= PUSH_W && 8'(i_pushNum_3) <= avail) push_ok = 1'b1;
        else                                                      err_set = 1'b1;
      end
    end else if (i_resolveValid) begin
      err_set = 1'b1;
    end

    ring_push_num = push_ok ? i_pushNum_3 : '0;
    count_next    = mispred ? '0 : count - 8'(match_pop) + 8'(ring_push_num);

    // Youngest entry goes to slot 0, so the oldest lands in the highest used slot.
    for (int unsigned s = 0; s < PUSH_W; s++) begin
      if (s < 32'(ring_push_num))
        ghr_next[s*ENTRY_W +: ENTRY_W] =
          i_pushEntry_36[(32'(ring_push_num) - 1 - s)*ENTRY_W +: ENTRY_W];
    end

    ready_next = ((state == ST_RUN && !mispred) ||
                  (state == ST_RECOVER && rec_cnt == '0)) &&
                 (8'(DEPTH) - count_next >= 8'(PUSH_W));
  end

  always_ff @(posedge fire or negedge rst) begin
    if (!rst) begin
      state            <= ST_RUN;
      rec_cnt          <= '0;
      o_ready          <= 1'b0;
      o_passBNum_3     <= '0;
      o_newPendingB_8  <= '0;
      o_newGHREntry_36 <= '0;
      o_redirect       <= 1'b0;
      o_redirectTaken  <= 1'b0;
      o_redirectTag_8  <= '0;
      o_err            <= 1'b0;
    end else begin
      o_passBNum_3     <= mispred ? PASS_CORRECTION : ring_push_num;
      o_newPendingB_8  <= mispred ? count : count_next;
      o_newGHREntry_36 <= ghr_next;
      o_redirect       <= mispred;
      o_redirectTaken  <= mispred & i_resolveTaken;
      o_redirectTag_8  <= mispred ? head_entry[TAG_MSB:TAG_LSB] : '0;
      o_err            <= o_err | err_set;
      o_ready          <= ready_next;

      case (state)
        ST_RUN: begin
          if (mispred) begin
            state   <= ST_RECOVER;
            rec_cnt <= 4'(RECOVER_CYCLES - 1);
          end
        end
        ST_RECOVER: begin
          if (rec_cnt == '0) state   <= ST_RUN;
          else               rec_cnt <= rec_cnt - 4'd1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_b_resolve_queue.sv
module tb_b_resolve_queue;

  localparam int DEPTH = 16;
  localparam int RC    = 2;

  logic        fire;
  logic        rst;
  logic [2:0]  d_pn;
  logic [35:0] d_ent;
  logic        d_rv;
  logic        d_rt;
  logic        o_ready;
  logic [2:0]  o_passBNum_3;
  logic [7:0]  o_newPendingB_8;
  logic [35:0] o_newGHREntry_36;
  logic [7:0]  o_pendingB_8;
  logic        o_redirect;
  logic        o_redirectTaken;
  logic [7:0]  o_redirectTag_8;
  logic        o_err;

  b_resolve_queue #(
    .DEPTH(DEPTH),
    .RECOVER_CYCLES(RC)
  ) dut (
    .fire            (fire),
    .rst             (rst),
    .i_pushNum_3     (d_pn),
    .i_pushEntry_36  (d_ent),
    .i_resolveValid  (d_rv),
    .i_resolveTaken  (d_rt),
    .o_ready         (o_ready),
    .o_passBNum_3    (o_passBNum_3),
    .o_newPendingB_8 (o_newPendingB_8),
    .o_newGHREntry_36(o_newGHREntry_36),
    .o_pendingB_8    (o_pendingB_8),
    .o_redirect      (o_redirect),
    .o_redirectTaken (o_redirectTaken),
    .o_redirectTag_8 (o_redirectTag_8),
    .o_err           (o_err)
  );

  initial fire = 1'b0;
  always #5 fire = ~fire;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of entries ----------------
  logic [8:0]  q[$];
  int          m_rec;
  bit          m_err;
  logic [2:0]  e_pass;
  int          e_np;
  logic [35:0] e_ghr;
  bit          e_redir;
  bit          e_rtaken;
  logic [7:0]  e_rtag;
  bit          e_ready;

  task automatic model_reset();
    q.delete();
    m_rec = 0;
    m_err = 0;
  endtask

  task automatic model_step(input logic [2:0] pn, input logic [35:0] ent,
                            input logic rv, input logic rt);
    int  old_size;
    bit  mis;
    logic [8:0] hd;
    old_size = q.size();
    mis      = 0;
    e_pass   = 0;
    e_ghr    = 0;
    e_redir  = 0;
    e_rtaken = 0;
    e_rtag   = 0;
    if (m_rec > 0) begin
      if (rv) m_err = 1;
      m_rec--;
    end else begin
      if (rv) begin
        if (q.size() == 0) m_err = 1;
        else begin
          hd = q[0];
          if (rt == hd[0]) void'(q.pop_front());
          else begin
            mis      = 1;
            e_pass   = 3'b111;
            e_redir  = 1;
            e_rtaken = rt;
            e_rtag   = hd[8:1];
            q.delete();
            m_rec    = RC;
          end
        end
      end
      if (!mis && pn != 0) begin
        if (pn <= 4 && int'(pn) <= DEPTH - q.size()) begin
          for (int k = 0; k < int'(pn); k++) begin
            q.push_back(ent[k*9 +: 9]);
            e_ghr = (e_ghr << 9) | 36'(ent[k*9 +: 9]);
          end
          e_pass = pn;
        end else m_err = 1;
      end
    end
    e_np    = mis ? old_size : q.size();
    e_ready = (m_rec == 0) && (DEPTH - q.size() >= 4);
  endtask

  task automatic drive(input logic [2:0] pn, input logic [35:0] ent,
                       input logic rv, input logic rt);
    @(negedge fire);
    d_pn  = pn;
    d_ent = ent;
    d_rv  = rv;
    d_rt  = rt;
    @(posedge fire);
    #1;
  endtask

  task automatic step_model(input logic [2:0] pn, input logic [35:0] ent,
                            input logic rv, input logic rt);
    drive(pn, ent, rv, rt);
    model_step(pn, ent, rv, rt);
    chk("m_pass",  36'(o_passBNum_3),     36'(e_pass));
    chk("m_newpb", 36'(o_newPendingB_8),  36'(e_np));
    chk("m_ghr",   o_newGHREntry_36,      e_ghr);
    chk("m_pend",  36'(o_pendingB_8),     36'(q.size()));
    chk("m_redir", 36'(o_redirect),       36'(e_redir));
    chk("m_ready", 36'(o_ready),          36'(e_ready));
    chk("m_err",   36'(o_err),            36'(m_err));
    if (e_redir) begin
      chk("m_rtaken", 36'(o_redirectTaken), 36'(e_rtaken));
      chk("m_rtag",   36'(o_redirectTag_8), 36'(e_rtag));
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_pass"},   36'(o_passBNum_3),    '0);
    chk({pfx, "_newpb"},  36'(o_newPendingB_8), '0);
    chk({pfx, "_ghr"},    o_newGHREntry_36,     '0);
    chk({pfx, "_pend"},   36'(o_pendingB_8),    '0);
    chk({pfx, "_redir"},  36'(o_redirect),      '0);
    chk({pfx, "_rtaken"}, 36'(o_redirectTaken), '0);
    chk({pfx, "_rtag"},   36'(o_redirectTag_8), '0);
    chk({pfx, "_ready"},  36'(o_ready),         '0);
    chk({pfx, "_err"},    36'(o_err),           '0);
  endtask

  task automatic do_reset();
    @(negedge fire);
    rst   = 1'b0;
    d_pn  = '0;
    d_ent = '0;
    d_rv  = 1'b0;
    d_rt  = 1'b0;
    #1;
    chk_all_zero("rst");
    repeat (2) @(negedge fire);
    rst = 1'b1;
    model_reset();
  endtask

  function automatic logic [35:0] rand_ent();
    logic [35:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  pn;
    logic [35:0] ent;
    logic        rv;
    logic        rt;
    logic [2:0]  x_pass;
    logic [7:0]  x_np;
    logic [35:0] x_ghr;
    logic [7:0]  x_pend;
    logic        x_redir;
    logic        x_rtaken;
    logic [7:0]  x_rtag;
    logic        x_ready;
    logic        x_err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [35:0] e;
    logic [8:0]  hd;
    rst   = 1'b0;
    d_pn  = '0;
    d_ent = '0;
    d_rv  = 1'b0;
    d_rt  = 1'b0;

    // Push 3, resolve-match, matched pop + push 4, mispredict with wrong-path push,
    // push during recovery, recovery exit, resolve on empty.
    tbl[0] = '{3'd3, {9'h000, 9'h1FF, 9'h0B0, 9'h1A1}, 1'b0, 1'b0,
               3'd3, 8'd3, {9'h000, 9'h1A1, 9'h0B0, 9'h1FF}, 8'd3, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{3'd0, 36'h0, 1'b1, 1'b1,
               3'd0, 8'd2, 36'h0, 8'd2, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{3'd4, {9'h009, 9'h007, 9'h005, 9'h003}, 1'b1, 1'b0,
               3'd4, 8'd5, {9'h003, 9'h005, 9'h007, 9'h009}, 8'd5, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3] = '{3'd2, {18'h0, 9'h011, 9'h013}, 1'b1, 1'b0,
               3'd7, 8'd5, 36'h0, 8'd0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{3'd1, {27'h0, 9'h015}, 1'b0, 1'b0,
               3'd0, 8'd0, 36'h0, 8'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{3'd0, 36'h0, 1'b0, 1'b0,
               3'd0, 8'd0, 36'h0, 8'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{3'd0, 36'h0, 1'b1, 1'b0,
               3'd0, 8'd0, 36'h0, 8'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(negedge fire);
    #1;
    chk_all_zero("init");
    @(negedge fire);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].pn, tbl[i].ent, tbl[i].rv, tbl[i].rt);
      chk($sformatf("t%0d_pass", i),  36'(o_passBNum_3),    36'(tbl[i].x_pass));
      chk($sformatf("t%0d_newpb", i), 36'(o_newPendingB_8), 36'(tbl[i].x_np));
      chk($sformatf("t%0d_ghr", i),   o_newGHREntry_36,     tbl[i].x_ghr);
      chk($sformatf("t%0d_pend", i),  36'(o_pendingB_8),    36'(tbl[i].x_pend));
      chk($sformatf("t%0d_redir", i), 36'(o_redirect),      36'(tbl[i].x_redir));
      chk($sformatf("t%0d_ready", i), 36'(o_ready),         36'(tbl[i].x_ready));
      chk($sformatf("t%0d_err", i),   36'(o_err),           36'(tbl[i].x_err));
      if (tbl[i].x_redir) begin
        chk($sformatf("t%0d_rtaken", i), 36'(o_redirectTaken), 36'(tbl[i].x_rtaken));
        chk($sformatf("t%0d_rtag", i),   36'(o_redirectTag_8),  36'(tbl[i].x_rtag));
      end
    end

    // Overflow near full: fill to 14, push 4 dropped, then push 2 with matched pop -> 15
    do_reset();
    for (int i = 0; i < 3; i++) step_model(3'd4, rand_ent(), 1'b0, 1'b0);
    step_model(3'd2, rand_ent(), 1'b0, 1'b0);
    chk("fill14", 36'(o_pendingB_8), 36'd14);
    step_model(3'd4, rand_ent(), 1'b0, 1'b0);
    chk("ovf_err", 36'(o_err), 36'd1);
    chk("ovf_pend", 36'(o_pendingB_8), 36'd14);
    hd = q[0];
    step_model(3'd2, rand_ent(), 1'b1, hd[0]);
    chk("pop_push15", 36'(o_pendingB_8), 36'd15);

    // Pointer wrap: 40 push/resolve pairs, FIFO order checked via redirects never firing
    do_reset();
    for (int i = 0; i < 40; i++) begin
      e = rand_ent();
      if (q.size() > 0) begin
        hd = q[0];
        step_model(3'd1, e, 1'b1, hd[0]);
      end else step_model(3'd1, e, 1'b0, 1'b0);
    end
    // Drain and confirm tags by forcing a mispredict on each remaining head
    hd = q[0];
    step_model(3'd0, 36'h0, 1'b1, ~hd[0]);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [2:0] pn;
      logic       rv;
      logic       rt;
      pn = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      rv = 1'($urandom_range(0, 1));
      if (q.size() > 0 && $urandom_range(0, 9) != 0) begin
        hd = q[0];
        rt = hd[0];
      end else rt = 1'($urandom_range(0, 1));
      step_model(pn, rand_ent(), rv, rt);
    end

    // Reset asserted mid-recovery
    do_reset();
    step_model(3'd1, {27'h0, 9'h0C3}, 1'b0, 1'b0);
    step_model(3'd0, 36'h0, 1'b1, 1'b0);
    chk("mr_redir", 36'(o_redirect), 36'd1);
    @(negedge fire);
    rst  = 1'b0;
    d_rv = 1'b0;
    #1;
    chk_all_zero("mr");
    @(negedge fire);
    rst = 1'b1;
    model_reset();
    step_model(3'd0, 36'h0, 1'b0, 1'b0);
    chk("mr_ready", 36'(o_ready), 36'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
